// File: rtl/diff_scan.sv
// diff_scan: multi-cycle first-differing-bit locator.
// XORs two operands on an accepted start, then walks the difference word
// CHUNK bits per cycle, either LSB-first (mode=0) or MSB-first (mode=1).
// The result is a one-hot mask, a binary index and a found flag, and a
// one-cycle done pulse marks it. WIDTH must be a multiple of CHUNK and
// greater than 1.
module diff_scan #(
  parameter  int WIDTH = 32,
  parameter  int CHUNK = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             found_q, found_d;

  logic [CNT_W-1:0] chunk_sel;
  logic [CHUNK-1:0] chunk_bits;
  logic [IDX_W-1:0] chunk_base;
  logic [IDX_W-1:0] hit_off;
  logic [IDX_W-1:0] hit_idx;
  logic             last_chunk;

  // Pick the chunk under inspection and locate the selected set bit inside it.
  always_comb begin
    chunk_sel  = mode_q ? (CNT_W'(NCH - 1) - cnt_q) : cnt_q;
    chunk_bits = '0;
    chunk_base = '0;
    for (int c = 0; c < NCH; c++) begin
      if (chunk_sel == CNT_W'(c)) begin
        chunk_bits = x_q[c*CHUNK +: CHUNK];
        chunk_base = IDX_W'(c * CHUNK);
      end
    end
    hit_off = '0;
    if (mode_q) begin
      // ascending sweep: the last set bit seen is the highest
      for (int b = 0; b < CHUNK; b++) begin
        if (chunk_bits[b]) hit_off = IDX_W'(b);
      end
    end else begin
      // descending sweep: the last set bit seen is the lowest
      for (int b = CHUNK - 1; b >= 0; b--) begin
        if (chunk_bits[b]) hit_off = IDX_W'(b);
      end
    end
    hit_idx    = chunk_base + hit_off;
    last_chunk = (cnt_q == CNT_W'(NCH - 1));
  end

  // Next-state and registered-output computation for the IDLE/SCAN controller.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    idx_d   = idx_q;
    found_d = found_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = in1 ^ in2;
          mode_d  = mode;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (|chunk_bits) begin
          out_d          = '0;
          out_d[hit_idx] = 1'b1;
          idx_d          = hit_idx;
          found_d        = 1'b1;
          done_d         = 1'b1;
          busy_d         = 1'b0;
          state_d        = IDLE;
        end else if (last_chunk) begin
          out_d   = '0;
          idx_d   = '0;
          found_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any scan in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      found_q <= found_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign out   = out_q;
  assign idx   = idx_q;
  assign found = found_q;

endmodule

// File: tb/tb_diff_scan.sv
// Testbench for diff_scan: directed cases plus randomized regression over
// four WIDTH/CHUNK configurations against a bit-position reference model.
module tb_diff_scan;

  logic        clk;
  logic        rst_n;
  logic        start_t;
  logic        mode_t;
  logic [63:0] in1_t;
  logic [63:0] in2_t;
  int          cfg;
  int          cfg_w;
  int          cfg_c;
  int          n_cmp;
  int          n_err;

  logic        busy0, done0, found0;
  logic [31:0] out0;
  logic [4:0]  idx0;
  logic        busy1, done1, found1;
  logic [31:0] out1;
  logic [4:0]  idx1;
  logic        busy2, done2, found2;
  logic [63:0] out2;
  logic [5:0]  idx2;
  logic        busy3, done3, found3;
  logic [15:0] out3;
  logic [3:0]  idx3;

  logic        busy_c, done_c, found_c;
  logic [63:0] out_c;
  logic [63:0] idx_c;

  diff_scan #(.WIDTH(32), .CHUNK(8)) u_32_8 (
    .clk(clk), .rst_n(rst_n), .start(start_t && cfg == 0),
    .in1(in1_t[31:0]), .in2(in2_t[31:0]), .mode(mode_t),
    .busy(busy0), .done(done0), .out(out0), .idx(idx0), .found(found0));

  diff_scan #(.WIDTH(32), .CHUNK(1)) u_32_1 (
    .clk(clk), .rst_n(rst_n), .start(start_t && cfg == 1),
    .in1(in1_t[31:0]), .in2(in2_t[31:0]), .mode(mode_t),
    .busy(busy1), .done(done1), .out(out1), .idx(idx1), .found(found1));

  diff_scan #(.WIDTH(64), .CHUNK(16)) u_64_16 (
    .clk(clk), .rst_n(rst_n), .start(start_t && cfg == 2),
    .in1(in1_t), .in2(in2_t), .mode(mode_t),
    .busy(busy2), .done(done2), .out(out2), .idx(idx2), .found(found2));

  diff_scan #(.WIDTH(16), .CHUNK(16)) u_16_16 (
    .clk(clk), .rst_n(rst_n), .start(start_t && cfg == 3),
    .in1(in1_t[15:0]), .in2(in2_t[15:0]), .mode(mode_t),
    .busy(busy3), .done(done3), .out(out3), .idx(idx3), .found(found3));

  // route the configuration under test onto common observation signals
  always_comb begin
    busy_c  = busy0;
    done_c  = done0;
    found_c = found0;
    out_c   = {32'd0, out0};
    idx_c   = {59'd0, idx0};
    case (cfg)
      1: begin
        busy_c = busy1; done_c = done1; found_c = found1;
        out_c = {32'd0, out1}; idx_c = {59'd0, idx1};
      end
      2: begin
        busy_c = busy2; done_c = done2; found_c = found2;
        out_c = out2; idx_c = {58'd0, idx2};
      end
      3: begin
        busy_c = busy3; done_c = done3; found_c = found3;
        out_c = {48'd0, out3}; idx_c = {60'd0, idx3};
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: position of the lowest/highest differing bit, and the scan
  // step at which its chunk is reached.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input bit m,
                                input int w, input int ch,
                                output bit f, output int ix, output int lat);
    logic [63:0] x;
    int nch;
    x = a ^ b;
    if (w < 64) x = x & ((64'd1 << w) - 64'd1);
    nch = w / ch;
    f   = 1'b0;
    ix  = 0;
    for (int i = 0; i < w; i++) begin
      if (x[i]) begin
        if (!f || m) ix = i;
        f = 1'b1;
      end
    end
    if (!f)     lat = nch;
    else if (m) lat = nch - ix / ch;
    else        lat = ix / ch + 1;
  endfunction

  task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input bit m, input string tag);
    bit          f;
    int          ix, lat, n;
    logic [63:0] held_out, held_idx, held_found;
    model(a, b, m, cfg_w, cfg_c, f, ix, lat);
    @(negedge clk);
    in1_t = a; in2_t = b; mode_t = m; start_t = 1'b1;
    held_out = out_c; held_idx = idx_c; held_found = {63'd0, found_c};
    @(posedge clk); #1;
    start_t = 1'b0;
    check({tag, "_busy_acc"}, {63'd0, busy_c}, 64'd1);
    check({tag, "_out_acc"}, out_c, held_out);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!done_c) begin
        check({tag, "_busy_scan"}, {63'd0, busy_c}, 64'd1);
        check({tag, "_hold"}, {out_c[62:0] ^ idx_c[62:0], found_c}, {held_out[62:0] ^ held_idx[62:0], held_found[0]});
        in1_t = {$urandom, $urandom};
        in2_t = {$urandom, $urandom};
        mode_t = ~mode_t;
      end
    end while (!done_c && n < 200);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_busy_done"}, {63'd0, busy_c}, 64'd0);
    check({tag, "_found"}, {63'd0, found_c}, {63'd0, f});
    check({tag, "_idx"}, idx_c, 64'(ix));
    check({tag, "_out"}, out_c, f ? (64'd1 << ix) : 64'd0);
  endtask

  // per-cycle invariants on the configuration under test
  always @(negedge clk) begin
    if (rst_n) begin
      check("inv_busy_done", {63'd0, busy_c & done_c}, 64'd0);
      if (found_c) check("inv_onehot", out_c, 64'd1 << idx_c);
      else         check("inv_none", out_c | idx_c, 64'd0);
    end
  end

  function automatic logic [63:0] rnd_sparse(input logic [63:0] a, input int w);
    logic [63:0] b;
    b = a ^ (64'd1 << $urandom_range(w - 1, 0));
    if ($urandom_range(1, 0) == 1) b = b ^ (64'd1 << $urandom_range(w - 1, 0));
    return b;
  endfunction

  initial begin
    logic [63:0] a, b;
    int kind;
    n_cmp = 0; n_err = 0;
    start_t = 1'b0; mode_t = 1'b0; in1_t = '0; in2_t = '0;
    cfg = 0; cfg_w = 32; cfg_c = 8;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy_c}, 64'd0);
    check("rst_done", {63'd0, done_c}, 64'd0);
    check("rst_out", out_c, 64'd0);
    check("rst_idx", idx_c, 64'd0);
    check("rst_found", {63'd0, found_c}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(64'h0, 64'h100, 1'b0, "t1");
    run_txn(64'hFFFFFFFF, 64'h7FFFFFFE, 1'b1, "t2_m1");
    run_txn(64'hFFFFFFFF, 64'h7FFFFFFE, 1'b0, "t2_m0");
    run_txn(64'h12345678, 64'h12345678, 1'b0, "t3");
    @(posedge clk); #1;
    check("t3_done_once", {63'd0, done_c}, 64'd0);

    // start requests during a scan must be ignored
    @(negedge clk);
    in1_t = 64'h0; in2_t = 64'h01000000; mode_t = 1'b0; start_t = 1'b1;
    @(posedge clk); #1;
    check("t4_busy_acc", {63'd0, busy_c}, 64'd1);
    in1_t = 64'hFFFF; in2_t = 64'h0; mode_t = 1'b1;
    @(posedge clk); #1;
    check("t4_done_c1", {63'd0, done_c}, 64'd0);
    @(posedge clk); #1;
    check("t4_done_c2", {63'd0, done_c}, 64'd0);
    start_t = 1'b0;
    @(posedge clk); #1;
    check("t4_done_c3", {63'd0, done_c}, 64'd0);
    @(posedge clk); #1;
    check("t4_done_c4", {63'd0, done_c}, 64'd1);
    check("t4_idx", idx_c, 64'd24);
    check("t4_out", out_c, 64'h01000000);
    run_txn(64'h0, 64'h1, 1'b0, "t4_b2b");

    // asynchronous reset in the middle of a scan
    @(negedge clk);
    in1_t = 64'h12345678; in2_t = 64'h12345678; mode_t = 1'b0; start_t = 1'b1;
    @(posedge clk); #1;
    start_t = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy", {63'd0, busy_c}, 64'd0);
    check("t5_done", {63'd0, done_c}, 64'd0);
    check("t5_out", out_c, 64'd0);
    check("t5_idx", idx_c, 64'd0);
    check("t5_found", {63'd0, found_c}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t5_no_stray", {62'd0, done_c, busy_c}, 64'd0);
    end
    run_txn(64'h0, 64'h4, 1'b1, "t5_fresh");

    // randomized regression across configurations
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cfg = c;
      case (c)
        0: begin cfg_w = 32; cfg_c = 8;  end
        1: begin cfg_w = 32; cfg_c = 1;  end
        2: begin cfg_w = 64; cfg_c = 16; end
        default: begin cfg_w = 16; cfg_c = 16; end
      endcase
      for (int t = 0; t < 40; t++) begin
        a = {$urandom, $urandom};
        kind = $urandom_range(3, 0);
        if (kind == 0)      b = a;
        else if (kind == 3) b = {$urandom, $urandom};
        else                b = rnd_sparse(a, cfg_w);
        run_txn(a, b, 1'($urandom_range(1, 0)), "rnd");
      end
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
